// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline interlock controller: FSM states and
// scoreboard entries, plus the scoreboard match helper.
package hazard_pkg;

  typedef enum logic [1:0] {RUN = 2'd0, BR_WAIT = 2'd1} hz_state_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] rd;
  } sb_entry_t;

  localparam int SB_DEPTH = 3;

  function automatic logic sb_hit(input sb_entry_t e, input logic [3:0] sel);
    return e.valid && (e.rd == sel);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Decode-side request and pipe-control bundle between the pipeline
// (master) and the hazard controller (slave).
interface pipe_hazard_ctrl_if #(parameter int selectionBits = 4);
  logic                     dec_valid;
  logic [selectionBits-1:0] dec_rs1;
  logic [selectionBits-1:0] dec_rs2;
  logic                     dec_rs1_used;
  logic                     dec_rs2_used;
  logic                     dec_wr_en;
  logic [selectionBits-1:0] dec_rd;
  logic                     dec_branch;
  logic                     mem_branch_taken;
  logic                     hold_fd;
  logic                     kill_fd;
  logic                     bubble_de;
  logic                     kill_em;

  modport master (
    output dec_valid, dec_rs1, dec_rs2, dec_rs1_used, dec_rs2_used,
           dec_wr_en, dec_rd, dec_branch, mem_branch_taken,
    input  hold_fd, kill_fd, bubble_de, kill_em
  );

  modport slave (
    input  dec_valid, dec_rs1, dec_rs2, dec_rs1_used, dec_rs2_used,
           dec_wr_en, dec_rd, dec_branch, mem_branch_taken,
    output hold_fd, kill_fd, bubble_de, kill_em
  );
endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating event counter: holds at all-ones instead of wrapping.
module hz_sat_counter #(
  parameter int width = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [width-1:0] count
);

  // Count up on inc until all-ones is reached
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {width{1'b1}})) begin
      count <= count + {{(width-1){1'b0}}, 1'b1};
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// RAW interlock and taken-branch flush controller with debug counters.
// Optional macro BRANCH_SPECULATE_EN: fetch past branches, no BR_WAIT.
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int registerQuantity = 16,
  parameter int selectionBits    = 4,
  parameter int counterWidth     = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  pipe_hazard_ctrl_if.slave       bus,
  output logic [1:0]              state_o,
  output logic [counterWidth-1:0] stall_cnt,
  output logic [counterWidth-1:0] flush_cnt
);

  // Scoreboard entries carry 4-bit selectors; reject configurations that do not fit.
  if ((selectionBits != 4) || (registerQuantity > (1 << selectionBits))) begin : g_bad_cfg
    $error("pipe_hazard_ctrl: unsupported register configuration");
  end

  hz_state_t  state_r;
  logic [1:0] wait_cnt_r;
  sb_entry_t  sb_r [SB_DEPTH];

  logic hazard_s;
  logic flush_s;
  logic issue_s;
  logic stall_inc_s;

  // Source match against EX, MEM and WB writers (WB included: regfile writes late)
  always_comb begin
    hazard_s = 1'b0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (bus.dec_valid &&
          ((bus.dec_rs1_used && sb_hit(sb_r[i], bus.dec_rs1)) ||
           (bus.dec_rs2_used && sb_hit(sb_r[i], bus.dec_rs2)))) begin
        hazard_s = 1'b1;
      end else begin
        hazard_s = hazard_s;
      end
    end
  end

  assign flush_s     = bus.mem_branch_taken;
  assign issue_s     = bus.dec_valid & ~hazard_s & ~flush_s & (state_r == RUN);
  assign stall_inc_s = bus.bubble_de & ~flush_s;
  assign state_o     = state_r;

  // Pipe controls; flush overrides both the hazard stall and the branch wait
  always_comb begin
    bus.hold_fd   = 1'b0;
    bus.kill_fd   = 1'b0;
    bus.bubble_de = 1'b0;
    bus.kill_em   = 1'b0;
    if (flush_s) begin
      bus.kill_fd   = 1'b1;
      bus.bubble_de = 1'b1;
      bus.kill_em   = 1'b1;
    end else if ((state_r == BR_WAIT) || hazard_s) begin
      bus.hold_fd   = 1'b1;
      bus.bubble_de = 1'b1;
    end else begin
      bus.hold_fd   = 1'b0;
      bus.bubble_de = 1'b0;
    end
  end

  // Scoreboard shift EX -> MEM -> WB; a flush squashes the EX writer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SB_DEPTH; i++) begin
        sb_r[i] <= '0;
      end
    end else begin
      sb_r[0] <= '{valid: issue_s & bus.dec_wr_en, rd: bus.dec_rd};
      sb_r[1] <= '{valid: sb_r[0].valid & ~flush_s, rd: sb_r[0].rd};
      sb_r[2] <= sb_r[1];
    end
  end

  // Branch-wait FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= RUN;
      wait_cnt_r <= 2'd0;
    end else begin
      case (state_r)
        RUN: begin
`ifdef BRANCH_SPECULATE_EN
          state_r    <= RUN;
          wait_cnt_r <= 2'd0;
`else
          if (issue_s && bus.dec_branch) begin
            state_r    <= BR_WAIT;
            wait_cnt_r <= 2'd2;
          end else begin
            state_r    <= RUN;
            wait_cnt_r <= 2'd0;
          end
`endif
        end
        BR_WAIT: begin
          wait_cnt_r <= wait_cnt_r - 2'd1;
          if (flush_s || (wait_cnt_r == 2'd1)) begin
            state_r <= RUN;
          end else begin
            state_r <= BR_WAIT;
          end
        end
        default: begin
          state_r    <= RUN;
          wait_cnt_r <= 2'd0;
        end
      endcase
    end
  end

  hz_sat_counter #(.width(counterWidth)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc_s),
    .count (stall_cnt)
  );

  hz_sat_counter #(.width(counterWidth)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_s),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic
// checked against an issue-age model; a 4-bit-counter copy checks saturation.
module tb_pipe_hazard_ctrl;

`ifdef BRANCH_SPECULATE_EN
  localparam bit SPEC = 1'b1;
`else
  localparam bit SPEC = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.selectionBits(4)) bus ();
  pipe_hazard_ctrl_if #(.selectionBits(4)) bus2 ();

  assign bus2.dec_valid        = bus.dec_valid;
  assign bus2.dec_rs1          = bus.dec_rs1;
  assign bus2.dec_rs2          = bus.dec_rs2;
  assign bus2.dec_rs1_used     = bus.dec_rs1_used;
  assign bus2.dec_rs2_used     = bus.dec_rs2_used;
  assign bus2.dec_wr_en        = bus.dec_wr_en;
  assign bus2.dec_rd           = bus.dec_rd;
  assign bus2.dec_branch       = bus.dec_branch;
  assign bus2.mem_branch_taken = bus.mem_branch_taken;

  logic [1:0]  state_o, state2;
  logic [15:0] stall_cnt, flush_cnt;
  logic [3:0]  stall2, flush2;

  pipe_hazard_ctrl #(.registerQuantity(16), .selectionBits(4), .counterWidth(16)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .state_o(state_o), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_hazard_ctrl #(.registerQuantity(16), .selectionBits(4), .counterWidth(4)) dut4 (
    .clk(clk), .rst(rst), .bus(bus2),
    .state_o(state2), .stall_cnt(stall2), .flush_cnt(flush2)
  );

  int total = 0;
  int bad   = 0;

  task automatic drive(input logic v, input logic [3:0] rs1, input logic [3:0] rs2,
                       input logic u1, input logic u2, input logic we,
                       input logic [3:0] rd, input logic br, input logic mbt);
    bus.dec_valid        = v;
    bus.dec_rs1          = rs1;
    bus.dec_rs2          = rs2;
    bus.dec_rs1_used     = u1;
    bus.dec_rs2_used     = u2;
    bus.dec_wr_en        = we;
    bus.dec_rd           = rd;
    bus.dec_branch       = br;
    bus.mem_branch_taken = mbt;
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    @(negedge clk);
    total++;
    if ({bus.hold_fd, bus.kill_fd, bus.bubble_de, bus.kill_em} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_ctrl got=%b want=0000", {bus.hold_fd, bus.kill_fd, bus.bubble_de, bus.kill_em});
    end
    total++;
    if (state_o !== 2'd0) begin
      bad++;
      $display("FAIL reset_state got=%0d want=0", state_o);
    end
    total++;
    if ({stall_cnt, flush_cnt} !== 32'd0) begin
      bad++;
      $display("FAIL reset_counters got=%0d/%0d want=0/0", stall_cnt, flush_cnt);
    end
    do_reset();
  endtask

  task automatic test_raw_hazard();
    int  cnt;
    bit  done;
    do_reset();
    drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0);
    @(negedge clk);
    total++;
    if (bus.hold_fd !== 1'b0) begin
      bad++;
      $display("FAIL raw_producer_hold got=%b want=0", bus.hold_fd);
    end
    next_cycle();
    cnt  = 0;
    done = 1'b0;
    for (int i = 0; i < 8 && !done; i++) begin
      drive(1'b1, 4'd3, 4'd9, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
      @(negedge clk);
      if (bus.hold_fd === 1'b1) begin
        cnt++;
        total++;
        if (bus.bubble_de !== 1'b1) begin
          bad++;
          $display("FAIL raw_bubble got=%b want=1", bus.bubble_de);
        end
        next_cycle();
      end else begin
        done = 1'b1;
      end
    end
    total++;
    if (cnt !== 3) begin
      bad++;
      $display("FAIL raw_stall_len got=%0d want=3", cnt);
    end
    next_cycle();
    idle();
    @(negedge clk);
    total++;
    if (stall_cnt !== 16'd3) begin
      bad++;
      $display("FAIL raw_stall_cnt got=%0d want=3", stall_cnt);
    end
    next_cycle();
  endtask

  task automatic test_no_stall();
    do_reset();
    drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0);
    @(negedge clk);
    next_cycle();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 1'b1, 4'(6 + k), 1'b0, 1'b0);
      @(negedge clk);
      total++;
      if (bus.hold_fd !== 1'b0) begin
        bad++;
        $display("FAIL indep_hold k=%0d got=%b want=0", k, bus.hold_fd);
      end
      next_cycle();
    end
    drive(1'b1, 4'd0, 4'd5, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    total++;
    if (bus.hold_fd !== 1'b0) begin
      bad++;
      $display("FAIL late_reader_hold got=%b want=0", bus.hold_fd);
    end
    next_cycle();
    idle();
    @(negedge clk);
    total++;
    if (stall_cnt !== 16'd0) begin
      bad++;
      $display("FAIL no_stall_cnt got=%0d want=0", stall_cnt);
    end
  endtask

  task automatic test_flush();
    do_reset();
    drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0, 1'b0);
    @(negedge clk);
    next_cycle();
    drive(1'b1, 4'd2, 4'd0, 1'b1, 1'b0, 1'b1, 4'd7, 1'b0, 1'b1);
    @(negedge clk);
    total++;
    if ({bus.kill_fd, bus.bubble_de, bus.kill_em, bus.hold_fd} !== 4'b1110) begin
      bad++;
      $display("FAIL flush_ctrl got=%b want=1110", {bus.kill_fd, bus.bubble_de, bus.kill_em, bus.hold_fd});
    end
    next_cycle();
    drive(1'b1, 4'd2, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    total++;
    if (bus.hold_fd !== 1'b0) begin
      bad++;
      $display("FAIL flush_ex_cleared got=%b want=0", bus.hold_fd);
    end
    next_cycle();
    idle();
    @(negedge clk);
    total++;
    if ({stall_cnt, flush_cnt} !== {16'd0, 16'd1}) begin
      bad++;
      $display("FAIL flush_counters got=%0d/%0d want=0/1", stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_branch_wait();
    do_reset();
    drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    @(negedge clk);
    total++;
    if ({bus.hold_fd, state_o} !== 3'b000) begin
      bad++;
      $display("FAIL branch_issue got=%b want=000", {bus.hold_fd, state_o});
    end
    next_cycle();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 4'd1, 4'd1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
      @(negedge clk);
      total++;
      if ({bus.hold_fd, bus.bubble_de, state_o} !== {!SPEC, !SPEC, 1'b0, !SPEC}) begin
        bad++;
        $display("FAIL branch_wait i=%0d got=%b want=%b", i,
                 {bus.hold_fd, bus.bubble_de, state_o}, {!SPEC, !SPEC, 1'b0, !SPEC});
      end
      next_cycle();
    end
    @(negedge clk);
    total++;
    if ({bus.hold_fd, state_o} !== 3'b000) begin
      bad++;
      $display("FAIL branch_done got=%b want=000", {bus.hold_fd, state_o});
    end
    next_cycle();
    idle();
    @(negedge clk);
    total++;
    if (stall_cnt !== (SPEC ? 16'd0 : 16'd2)) begin
      bad++;
      $display("FAIL branch_stall_cnt got=%0d want=%0d", stall_cnt, SPEC ? 0 : 2);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0);
    next_cycle();
    drive(1'b1, 4'd3, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    total++;
    if (bus.hold_fd !== 1'b1) begin
      bad++;
      $display("FAIL arst_pre_stall got=%b want=1", bus.hold_fd);
    end
    next_cycle();
    #1 rst = 1'b1;
    #1;
    total++;
    if ({bus.hold_fd, bus.bubble_de, state_o, stall_cnt} !== 20'd0) begin
      bad++;
      $display("FAIL arst_mid_stall got=%b/%b/%0d/%0d want=0/0/0/0",
               bus.hold_fd, bus.bubble_de, state_o, stall_cnt);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total++;
    if (bus.hold_fd !== 1'b0) begin
      bad++;
      $display("FAIL arst_sb_empty got=%b want=0", bus.hold_fd);
    end
    next_cycle();
    drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    next_cycle();
    drive(1'b1, 4'd1, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    #1;
    total++;
    if (state_o !== {1'b0, !SPEC}) begin
      bad++;
      $display("FAIL arst_pre_wait got=%0d want=%0d", state_o, !SPEC);
    end
    #1 rst = 1'b1;
    #1;
    total++;
    if ({bus.hold_fd, bus.kill_fd, bus.bubble_de, bus.kill_em, state_o} !== 6'd0) begin
      bad++;
      $display("FAIL arst_mid_wait got=%b want=000000",
               {bus.hold_fd, bus.kill_fd, bus.bubble_de, bus.kill_em, state_o});
    end
    @(posedge clk);
    #1 rst = 1'b0;
    idle();
  endtask

  task automatic test_saturation();
    do_reset();
    for (int k = 0; k < 7; k++) begin
      drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 4'(k + 1), 1'b0, 1'b0);
      next_cycle();
      repeat (4) begin
        drive(1'b1, 4'(k + 1), 4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        next_cycle();
      end
    end
    idle();
    @(negedge clk);
    total++;
    if (stall_cnt !== 16'd21) begin
      bad++;
      $display("FAIL sat_wide got=%0d want=21", stall_cnt);
    end
    total++;
    if (stall2 !== 4'd15) begin
      bad++;
      $display("FAIL sat_narrow got=%0d want=15", stall2);
    end
  endtask

  task automatic test_random();
    int   w_rd[$];
    int   w_cyc[$];
    int   n, br_left, m_stall, m_flush, age;
    logic v, u1, u2, we, br, mbt, hz, waiting, issue;
    logic [3:0] rs1, rs2, rd, exp_ctrl, exp_sat;
    logic [1:0] exp_state;
    do_reset();
    n = 0; br_left = 0; m_stall = 0; m_flush = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      v   = ($urandom_range(0, 9) < 8);
      rs1 = 4'($urandom_range(0, 3));
      rs2 = 4'($urandom_range(0, 3));
      u1  = 1'($urandom_range(0, 1));
      u2  = 1'($urandom_range(0, 1));
      we  = 1'($urandom_range(0, 1));
      rd  = 4'($urandom_range(0, 3));
      br  = ($urandom_range(0, 9) == 0);
      mbt = ($urandom_range(0, 11) == 0);
      drive(v, rs1, rs2, u1, u2, we, rd, br, mbt);
      // A write issued in cycle c blocks readers in cycles c+1 .. c+3.
      hz = 1'b0;
      for (int i = 0; i < w_rd.size(); i++) begin
        age = n - w_cyc[i];
        if (v && age >= 1 && age <= 3 &&
            ((u1 && int'(rs1) == w_rd[i]) || (u2 && int'(rs2) == w_rd[i]))) hz = 1'b1;
      end
      waiting   = (br_left > 0);
      exp_ctrl  = mbt ? 4'b0111 : ((waiting || hz) ? 4'b1010 : 4'b0000);
      exp_state = waiting ? 2'd1 : 2'd0;
      exp_sat   = (m_stall > 15) ? 4'd15 : 4'(m_stall);
      @(negedge clk);
      total++;
      if ({bus.hold_fd, bus.kill_fd, bus.bubble_de, bus.kill_em} !== exp_ctrl ||
          state_o !== exp_state) begin
        bad++;
        $display("FAIL rand_ctrl cyc=%0d got=%b st=%0d want=%b st=%0d", cyc,
                 {bus.hold_fd, bus.kill_fd, bus.bubble_de, bus.kill_em}, state_o, exp_ctrl, exp_state);
      end
      total++;
      if (stall_cnt !== 16'(m_stall) || flush_cnt !== 16'(m_flush) || stall2 !== exp_sat) begin
        bad++;
        $display("FAIL rand_cnt cyc=%0d got=%0d/%0d/%0d want=%0d/%0d/%0d", cyc,
                 stall_cnt, flush_cnt, stall2, m_stall, m_flush, exp_sat);
      end
      issue = v && !hz && !mbt && !waiting;
      if (exp_ctrl[1] && !mbt) m_stall++;
      if (mbt) m_flush++;
      if (mbt && w_cyc.size() > 0 && w_cyc[$] == n - 1) begin
        void'(w_cyc.pop_back());
        void'(w_rd.pop_back());
      end
      if (issue && we) begin
        w_rd.push_back(int'(rd));
        w_cyc.push_back(n);
      end
      if (mbt) br_left = 0;
      else if (waiting) br_left--;
      else if (issue && br && !SPEC) br_left = 2;
      while (w_cyc.size() > 0 && n - w_cyc[0] >= 3) begin
        void'(w_cyc.pop_front());
        void'(w_rd.pop_front());
      end
      n++;
      next_cycle();
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_raw_hazard();
    test_no_stall();
    test_flush();
    test_branch_wait();
    test_async_reset();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
